// File: rtl/fir_param_pkg.sv
// rtl/fir_param_pkg.sv - FIR engine state encoding and width helpers
`timescale 1ns/1ps
package fir_param_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHIFT,
        MAC,
        OUT
    } state_t;

    // Index width that stays at least one bit for tiny counts.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int acc_width(input int data_w, input int num_taps);
        return 2 * data_w + $clog2(num_taps);
    endfunction

endpackage

// File: rtl/sync_rise_high.sv
// rtl/sync_rise_high.sv - 2-flop synchroniser with rising-edge detect, async active-high reset
`timescale 1ns/1ps
module sync_rise_high (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/fir_filter_param.sv
// rtl/fir_filter_param.sv - parametrised one-tap-per-cycle FIR engine returning |y|
// Optional macro FIR_SAT_EN: saturate the magnitude instead of wrapping it.
`timescale 1ns/1ps
module fir_filter_param
    import fir_param_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_TAPS   = 4,
    parameter int FRAC_BITS  = 15,
    parameter int SAMPLE_CNT = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sample_data,
    input  logic [DATA_W-1:0] fir_coefficient,
    input  logic              load_coeff,
    input  logic              data_ready,
    output logic              one_k_samples,
    output logic              modwait,
    output logic [DATA_W-1:0] fir_out,
    output logic              err
);

    localparam int ACC_W = acc_width(DATA_W, NUM_TAPS);
    localparam int TAP_W = idx_width(NUM_TAPS);
    localparam int CNT_W = idx_width(SAMPLE_CNT);

    state_t state, state_next;

    logic lc_rise, dr_rise;
    logic lc_pend, dr_pend;
    logic coeff_valid, err_seen;

    logic signed [DATA_W-1:0]   coeff  [NUM_TAPS];
    logic signed [DATA_W-1:0]   x_line [NUM_TAPS];
    logic        [TAP_W-1:0]    cidx, tap;
    logic signed [ACC_W-1:0]    acc, acc_shr;
    logic signed [2*DATA_W-1:0] prod;
    logic        [CNT_W-1:0]    sample_cnt;
    logic        [DATA_W-1:0]   fir_next;

    logic take_lc, take_dr, accept, reject, dr_drop, err_raise;

    sync_rise_high u_sync_lc (
        .clk      (clk),
        .rst      (rst),
        .async_in (load_coeff),
        .rise     (lc_rise)
    );

    sync_rise_high u_sync_dr (
        .clk      (clk),
        .rst      (rst),
        .async_in (data_ready),
        .rise     (dr_rise)
    );

    // Coefficient loads win over samples; a refused sample still consumes its edge.
    assign take_lc   = (state == IDLE) && (lc_rise || lc_pend);
    assign take_dr   = (state == IDLE) && !take_lc && (dr_rise || dr_pend);
    assign accept    = take_dr && coeff_valid;
    assign reject    = take_dr && !coeff_valid;
    assign dr_drop   = dr_rise && dr_pend && !take_dr;
    assign err_raise = dr_drop || reject;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (take_lc) begin
                    state_next = LOAD;
                end else if (accept) begin
                    state_next = SHIFT;
                end
            end
            LOAD:  state_next = IDLE;
            SHIFT: state_next = MAC;
            MAC: begin
                if (tap == TAP_W'(NUM_TAPS - 1)) begin
                    state_next = OUT;
                end
            end
            OUT:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign prod    = x_line[tap] * coeff[tap];
    assign acc_shr = acc >>> FRAC_BITS;

`ifdef FIR_SAT_EN
    logic [ACC_W-1:0] mag;
    always_comb begin
        mag      = acc_shr[ACC_W-1] ? $unsigned(-acc_shr) : $unsigned(acc_shr);
        fir_next = (|mag[ACC_W-1:DATA_W]) ? {DATA_W{1'b1}} : mag[DATA_W-1:0];
    end
`else
    always_comb begin
        fir_next = DATA_W'(acc_shr[ACC_W-1] ? -acc_shr : acc_shr);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lc_pend  <= 1'b0;
            dr_pend  <= 1'b0;
            err      <= 1'b0;
            err_seen <= 1'b0;
            modwait  <= 1'b0;
        end else begin
            lc_pend  <= take_lc ? (lc_pend & lc_rise) : (lc_pend | lc_rise);
            dr_pend  <= take_dr ? (dr_pend & dr_rise) : (dr_pend | dr_rise);
            err_seen <= accept ? 1'b0 : (err_seen | err_raise);
            modwait  <= (state_next != IDLE);
            if (err_raise) begin
                err <= 1'b1;
            end else if (state == OUT && !err_seen) begin
                err <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_TAPS; i++) begin
                coeff[i]  <= '0;
                x_line[i] <= '0;
            end
            cidx          <= '0;
            tap           <= '0;
            acc           <= '0;
            sample_cnt    <= '0;
            coeff_valid   <= 1'b0;
            fir_out       <= '0;
            one_k_samples <= 1'b0;
        end else begin
            one_k_samples <= 1'b0;
            case (state)
                LOAD: begin
                    coeff[cidx] <= fir_coefficient;
                    sample_cnt  <= '0;
                    if (cidx == TAP_W'(NUM_TAPS - 1)) begin
                        cidx        <= '0;
                        coeff_valid <= 1'b1;
                    end else begin
                        cidx <= cidx + 1'b1;
                    end
                end
                SHIFT: begin
                    for (int i = NUM_TAPS - 1; i > 0; i--) begin
                        x_line[i] <= x_line[i-1];
                    end
                    x_line[0] <= sample_data;
                    acc       <= '0;
                    tap       <= '0;
                end
                MAC: begin
                    acc <= acc + {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};
                    tap <= tap + 1'b1;
                end
                OUT: begin
                    fir_out <= fir_next;
                    if (sample_cnt == CNT_W'(SAMPLE_CNT - 1)) begin
                        sample_cnt    <= '0;
                        one_k_samples <= 1'b1;
                    end else begin
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_filter_param.sv
// tb/tb_fir_filter_param.sv - scoreboard bench for fir_filter_param
`timescale 1ns/1ps
module tb_fir_filter_param;

    localparam int DATA_W     = 16;
    localparam int NUM_TAPS   = 4;
    localparam int FRAC_BITS  = 15;
    localparam int SAMPLE_CNT = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] sample_data;
    logic [DATA_W-1:0] fir_coefficient;
    logic              load_coeff;
    logic              data_ready;
    logic              one_k_samples;
    logic              modwait;
    logic [DATA_W-1:0] fir_out;
    logic              err;

    always #5 clk = ~clk;

    fir_filter_param #(
        .DATA_W     (DATA_W),
        .NUM_TAPS   (NUM_TAPS),
        .FRAC_BITS  (FRAC_BITS),
        .SAMPLE_CNT (SAMPLE_CNT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .sample_data     (sample_data),
        .fir_coefficient (fir_coefficient),
        .load_coeff      (load_coeff),
        .data_ready      (data_ready),
        .one_k_samples   (one_k_samples),
        .modwait         (modwait),
        .fir_out         (fir_out),
        .err             (err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int k_cycles = 0;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    logic signed [DATA_W-1:0] cm [NUM_TAPS];
    logic signed [DATA_W-1:0] xm [NUM_TAPS];
    int     cidx_m;
    int     cnt_m;
    longint exp_q[$];
    bit     k_q[$];

    function automatic void model_reset();
        for (int i = 0; i < NUM_TAPS; i++) begin
            cm[i] = '0;
            xm[i] = '0;
        end
        cidx_m = 0;
        cnt_m  = 0;
    endfunction

    function automatic longint model_out();
        longint acc = 0;
        longint s;
        longint m;
        for (int k = 0; k < NUM_TAPS; k++) begin
            acc += longint'(xm[k]) * longint'(cm[k]);
        end
        s = acc >>> FRAC_BITS;
        m = (s < 0) ? -s : s;
`ifdef FIR_SAT_EN
        return (m > 65535) ? 65535 : m;
`else
        return m & 64'hFFFF;
`endif
    endfunction

    function automatic void model_load(input logic [DATA_W-1:0] c);
        cm[cidx_m] = c;
        cidx_m = (cidx_m == NUM_TAPS - 1) ? 0 : cidx_m + 1;
        cnt_m  = 0;
    endfunction

    function automatic void model_accept(input logic [DATA_W-1:0] d);
        for (int i = NUM_TAPS - 1; i > 0; i--) xm[i] = xm[i-1];
        xm[0] = d;
        exp_q.push_back(model_out());
        cnt_m++;
        if (cnt_m == SAMPLE_CNT) begin
            cnt_m = 0;
            k_q.push_back(1'b1);
        end else begin
            k_q.push_back(1'b0);
        end
    endfunction

    always @(negedge clk) if (one_k_samples === 1'b1) k_cycles++;

    task automatic wait_modwait(input logic lvl, input string tag);
        int n = 0;
        while (modwait !== lvl && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (modwait !== lvl) check_val({tag, "_timeout"}, longint'(modwait), longint'(lvl));
    endtask

    task automatic pop_check(input string tag);
        check_val({tag, "_pending"}, longint'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            check_val({tag, "_out"}, fir_out, exp_q.pop_front());
            check_val({tag, "_1k"}, one_k_samples, longint'(k_q.pop_front()));
        end
    endtask

    task automatic load_word(input logic [DATA_W-1:0] c);
        fir_coefficient = c;
        model_load(c);
        load_coeff = 1'b1;
        wait_modwait(1'b1, "load_busy");
        wait_modwait(1'b0, "load_done");
        load_coeff = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_sample(input logic [DATA_W-1:0] d, input string tag);
        sample_data = d;
        model_accept(d);
        data_ready = 1'b1;
        wait_modwait(1'b1, tag);
        wait_modwait(1'b0, tag);
        pop_check(tag);
        data_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic refused_sample(input logic [DATA_W-1:0] d, input string tag);
        bit saw_busy = 0;
        sample_data = d;
        data_ready  = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (modwait === 1'b1) saw_busy = 1;
        end
        check_val({tag, "_err"}, err, 1);
        check_val({tag, "_busy"}, longint'(saw_busy), 0);
        check_val({tag, "_out"}, fir_out, 0);
        data_ready = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [DATA_W-1:0] t1_in  [4];
        logic [DATA_W-1:0] t1_exp [4];
        logic [DATA_W-1:0] sat_exp;
        int k_before;
        t1_in  = '{16'h0100, 16'h0000, 16'h0000, 16'h0000};
        t1_exp = '{16'h0100, 16'h0080, 16'h0040, 16'h0020};

        rst = 1'b1;
        sample_data = '0;
        fir_coefficient = '0;
        load_coeff = 1'b0;
        data_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_val("rst_out", fir_out, 0);
        check_val("rst_modwait", modwait, 0);
        check_val("rst_err", err, 0);
        check_val("rst_1k", one_k_samples, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Sample with no coefficients is refused.
        refused_sample(16'h1234, "nocoef");

        load_word(16'h8000);
        load_word(16'h4000);
        load_word(16'h2000);
        load_word(16'h1000);
        check_val("load_keeps_err", err, 1);

        for (int i = 0; i < 4; i++) begin
            send_sample(t1_in[i], "basic");
            check_val("basic_lit", fir_out, t1_exp[i]);
            check_val("basic_err", err, 0);
        end

        // Two data_ready edges while busy: one pended, one dropped.
        sample_data = 16'h0200;
        model_accept(16'h0200);
        data_ready = 1'b1;
        wait_modwait(1'b1, "pend_a");
        data_ready = 1'b0;
        @(negedge clk);
        sample_data = 16'h0300;
        data_ready  = 1'b1;
        model_accept(16'h0300);
        @(negedge clk);
        data_ready = 1'b0;
        @(negedge clk);
        data_ready = 1'b1;
        wait_modwait(1'b0, "pend_a");
        pop_check("pend_a");
        check_val("drop_err", err, 1);
        wait_modwait(1'b1, "pend_b");
        wait_modwait(1'b0, "pend_b");
        pop_check("pend_b");
        check_val("pend_err_clr", err, 0);
        data_ready = 1'b0;
        repeat (3) @(negedge clk);

        // Fresh bank zeroes the sample counter, then 2000 samples.
        load_word(16'h1111);
        load_word(16'hE000);
        load_word(16'h0800);
        load_word(16'h3000);
        k_before = k_cycles;
        for (int i = 0; i < 2 * SAMPLE_CNT; i++) begin
            send_sample(16'($urandom), "bulk");
        end
        check_val("bulk_pulses", k_cycles - k_before, 2);

        // Large result: saturates or wraps depending on build.
        for (int i = 0; i < 4; i++) load_word(16'h7FFF);
        for (int i = 0; i < 4; i++) send_sample(16'h7FFF, "big");
`ifdef FIR_SAT_EN
        sat_exp = 16'hFFFF;
`else
        sat_exp = 16'hFFF8;
`endif
        check_val("big_lit", fir_out, sat_exp);

        // Reset in the middle of a MAC.
        sample_data = 16'h0100;
        data_ready  = 1'b1;
        wait_modwait(1'b1, "midrst");
        repeat (2) @(negedge clk);
        check_val("midrst_busy", modwait, 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        data_ready = 1'b0;
        #1;
        check_val("midrst_out", fir_out, 0);
        check_val("midrst_modwait", modwait, 0);
        check_val("midrst_err", err, 0);
        check_val("midrst_1k", one_k_samples, 0);
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        refused_sample(16'h0100, "postrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
